// File: rtl/vram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared constants and types for the character-cell VRAM arbiter.
//   COLS/ROWS    : character grid (640x480 pixels in 8x8 cells)
//   CELL_LOG2    : log2 of the cell width in pixels
//   H_WRAP       : last value of CounterX before it wraps to 0
//   FETCH_SLOT   : cell phase (CounterX[2:0]) that owns the display fetch
//   arb_state_t  : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package vram_arbiter_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 60;
    localparam int CELL_LOG2  = 3;
    localparam int H_WRAP     = 767;
    localparam int FETCH_SLOT = 5;

    localparam int ADDR_W = 13;   // cell address width, enough for COLS*ROWS
    localparam int COL_W  = 7;    // fetch column, holds up to 96
    localparam int ROW_W  = 7;    // fetch row, holds up to 64

    // Cell phases that follow the fetch: read data lands on the next phase,
    // and is promoted to the visible cell on the one after.
    localparam logic [CELL_LOG2-1:0] PH_FETCH   = CELL_LOG2'(FETCH_SLOT);
    localparam logic [CELL_LOG2-1:0] PH_CAPTURE = CELL_LOG2'(FETCH_SLOT + 1);
    localparam logic [CELL_LOG2-1:0] PH_COPY    = CELL_LOG2'(FETCH_SLOT + 2);

    // First CounterX of the final cell of a line; fetches from here on
    // already target column 0 of the following line.
    localparam logic [9:0] LINE_TAIL = 10'(H_WRAP + 1 - (1 << CELL_LOG2));

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        CPU_ACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if
// CPU access bus of the VRAM arbiter.
//   cpu_req    : request, held by the CPU until cpu_ack
//   cpu_we     : 1 = write, 0 = read
//   cpu_addr   : cell address row*COLS+col
//   cpu_wdata  : write data
//   cpu_ack    : one-cycle pulse in the cycle the access reaches the RAM
//   cpu_rvalid : one-cycle pulse one cycle after a read's cpu_ack
//   cpu_rdata  : read data, held until the next read completes
// master = CPU side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int DW = 8
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DW-1:0]     cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rvalid, cpu_rdata
    );

endinterface

// File: rtl/vram_arbiter_addr_gen.sv
// ---------------------------------------------------------------------------
// vram_addr_gen
// Linear cell address from a (row, col) pair: addr = row*COLS + col.
//   row  : cell row
//   col  : cell column
//   addr : cell address into the character RAM
// For the standard 80-column grid the multiply is two shifts and an add.
// ---------------------------------------------------------------------------
module vram_addr_gen
    import vram_arbiter_pkg::*;
#(
    parameter int COLS = vram_arbiter_pkg::COLS
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    generate
        if (COLS == 80) begin : gShift
            // 80 = 64 + 16
            assign addr = (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
        end else begin : gMul
            assign addr = ADDR_W'(32'(row) * COLS + 32'(col));
        end
    endgenerate

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port character RAM between the display refresh and a
// CPU. Every 8-pixel cell owns one display fetch slot (phase 5) that
// prefetches the next cell's colour; all other cycles, and every cycle whose
// slot falls outside the character grid, go to the CPU.
//   clk, rst_n        : pixel clock, async active-low reset
//   CounterX/Y        : sync generator position (X wraps at 767)
//   inDisplayArea     : visible-pixel flag
//   cpu               : CPU access bus (slave side)
//   mem_addr/we/wdata : registered RAM command
//   mem_rdata         : RAM data for the command presented in this cycle
//   pix_color         : colour for the current pixel, 1 cycle behind
//                       inDisplayArea
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int COLS = vram_arbiter_pkg::COLS,
    parameter int ROWS = vram_arbiter_pkg::ROWS,
    parameter int DW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        CounterX,
    input  logic [8:0]        CounterY,
    input  logic              inDisplayArea,
    vram_arbiter_if.slave     cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [DW-1:0]     pix_color
);

    arb_state_t            state;
    logic [CELL_LOG2-1:0]  phase;
    logic                  lineTail;
    logic [COL_W-1:0]      fetchCol;
    logic [ROW_W-1:0]      fetchRow;
    logic                  slotValid;
    logic [ADDR_W-1:0]     dispAddr;
    logic                  cpuOob;

    logic                  ackQ;
    logic                  rdPend;     // a CPU read is on the RAM this cycle
    logic                  rdZero;     // ...and it was out of range
    logic                  rvalidQ;
    logic [DW-1:0]         rdataQ;
    logic [DW-1:0]         shadow;
    logic [DW-1:0]         curCell;

    assign phase    = CounterX[CELL_LOG2-1:0];
    assign lineTail = (CounterX >= LINE_TAIL);

    // Fetch target for the cell after the current one. In the last cell of
    // a line that is column 0 of the next line, which may be a new row.
    // NOTE: every variable assigned in always_comb gets a value on every
    // path, otherwise synthesis infers a latch.
    always_comb begin
        fetchCol = '0;
        fetchRow = '0;
        if (lineTail) begin
            fetchCol = '0;
            fetchRow = ROW_W'(({1'b0, CounterY} + 10'd1) >> CELL_LOG2);
        end else begin
            fetchCol = CounterX[9:CELL_LOG2] + COL_W'(1);
            fetchRow = ROW_W'(CounterY >> CELL_LOG2);
        end
    end

    assign slotValid = (phase == PH_FETCH)
                    && (32'(fetchCol) < COLS)
                    && (32'(fetchRow) < ROWS);

    assign cpuOob = (32'(cpu.cpu_addr) >= COLS * ROWS);

    vram_addr_gen #(
        .COLS (COLS)
    ) uAddrGen (
        .row  (fetchRow),
        .col  (fetchCol),
        .addr (dispAddr)
    );

    // Arbiter FSM. The display slot always wins; a CPU request seen in the
    // same cycle simply wins on the next one because it is still held.
    // Out-of-range CPU accesses are acknowledged but never write the RAM.
    // NOTE: state and outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            ackQ      <= 1'b0;
            rdPend    <= 1'b0;
            rdZero    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            ackQ   <= 1'b0;
            rdPend <= 1'b0;
            if (slotValid) begin
                state    <= DISP_RD;
                mem_addr <= dispAddr;
            end else if (cpu.cpu_req) begin
                state     <= CPU_ACC;
                mem_addr  <= cpu.cpu_addr;
                mem_we    <= cpu.cpu_we && !cpuOob;
                mem_wdata <= cpu.cpu_wdata;
                ackQ      <= 1'b1;
                rdPend    <= !cpu.cpu_we;
                rdZero    <= cpuOob;
            end else begin
                state <= IDLE;
            end
        end
    end

    // CPU read return: RAM data belongs to the command issued this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalidQ <= 1'b0;
            rdataQ  <= '0;
        end else begin
            rvalidQ <= rdPend;
            if (rdPend) begin
                rdataQ <= rdZero ? '0 : mem_rdata;
            end
        end
    end

    // Display pipeline: fetch on phase 5, capture on 6, promote on 7 so the
    // new cell is stable from phase 0. A slot that fetched nothing leaves
    // the shadow untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            curCell   <= '0;
            pix_color <= '0;
        end else begin
            if (phase == PH_CAPTURE && state == DISP_RD) begin
                shadow <= mem_rdata;
            end
            if (phase == PH_COPY) begin
                curCell <= shadow;
            end
            pix_color <= inDisplayArea ? curCell : '0;
        end
    end

    assign cpu.cpu_ack    = ackQ;
    assign cpu.cpu_rvalid = rvalidQ;
    assign cpu.cpu_rdata  = rdataQ;

endmodule
